load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of REQ-state cycles without mem_ack before a bus error.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 req_valid  input  1  SHALL mark that the instruction in MEM carries a memory access.
REQ-005 mem_read, mem_write  input  1 each  SHALL select load or store.
REQ-006 funct3  input  3  SHALL give size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALU_out  input  32  SHALL be the effective address.
REQ-008 store_data  input  32  SHALL be the rs2 value to store.
REQ-009 data_out  output  32  SHALL be the aligned, extended load result for writeback selection.
REQ-010 stall  output  1  SHALL freeze upstream stages while an access is outstanding.
REQ-011 done  output  1  SHALL be a one-cycle pulse on access completion.
REQ-012 err  output  1  SHALL be a one-cycle pulse, coincident with done, flagging a failed access.
REQ-013 mem_req, mem_we  output  1 each  SHALL be the bus request and write strobe.
REQ-014 mem_addr  output  32  SHALL be {ALU_out[31:2],2'b00}.
REQ-015 mem_be  output  4, mem_wdata  output  32  SHALL be the byte enables and lane-replicated store data.
REQ-016 mem_ack  input  1, mem_rdata  input  32  SHALL be the bus acknowledge and read data.

Function
REQ-017 FSM SHALL have states IDLE, REQ, DONE.
REQ-018 IDLE -> REQ SHALL occur when req_valid & (mem_read ^ mem_write); req_valid with both or neither of mem_read/mem_write SHALL produce no access and no stall.
REQ-019 In REQ, mem_req SHALL be 1 and mem_addr/mem_be/mem_we/mem_wdata SHALL stay stable (registered at IDLE exit) until the cycle mem_ack is sampled high.
REQ-020 REQ -> DONE SHALL occur on mem_ack = 1; on a load, data_out SHALL be updated at that same edge.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE; req_valid seen in DONE SHALL be ignored.
REQ-022 stall SHALL be (IDLE & starting access) | REQ, combinational, and SHALL be 0 in DONE.
REQ-023 Minimum latency SHALL be 2 cycles (req_valid at edge N, mem_req in cycle N+1, ack in N+1, done in N+2).
REQ-024 Byte enables: B = 4'b0001<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111.
REQ-025 mem_wdata: B = {4{sd[7:0]}}; H = {2{sd[15:0]}}; W = sd.
REQ-026 Loads SHALL select the addressed lane, sign-extend for B/H and zero-extend for BU/HU.
REQ-027 Unlisted funct3 codes SHALL be treated as W.
REQ-028 Stores SHALL leave data_out unchanged.
REQ-029 A REQ cycle counter SHALL reach TIMEOUT_CYCLES without ack -> drop mem_req, go to DONE with err=1; a load SHALL then set data_out=0.
REQ-030 mem_ack outside REQ SHALL be ignored.

Reset
REQ-031 rst SHALL force state IDLE, counter 0, and data_out, stall, done, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata all to 0 at the next edge, including mid-REQ (the request is abandoned).

Configuration
REQ-032 Macro MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 SHALL skip REQ, go IDLE->DONE with err=1, issue no mem_req, and leave data_out unchanged.
REQ-033 Macro MISALIGN_TRAP_EN undefined: the low address bits not used by REQ-024 SHALL be ignored (access aligned down), with no error.

Verification
REQ-034 LW at 0x100, ack in first REQ cycle, rdata 0xDEADBEEF -> mem_be 1111, done 2 cycles after req_valid, data_out 0xDEADBEEF, stall high exactly 2 cycles.
REQ-035 LB at 0x103 with rdata 0x80FFFFFF -> data_out 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-036 SH at 0x202 with store_data 0x1234ABCD -> mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1, data_out unchanged.
REQ-037 With TIMEOUT_CYCLES=4, load never acked -> mem_req high 4 cycles, then done=err=1 and data_out=0.
REQ-038 rst asserted in the 2nd REQ cycle -> next edge mem_req=0, stall=0, no done pulse.
REQ-039 With MISALIGN_TRAP_EN, LW at 0x102 -> no mem_req, done=err=1 one cycle after req_valid; without the macro -> mem_addr 0x100, normal completion.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: issues one bus access per MEM-stage memory instruction,
// produces byte enables and lane-replicated store data, and aligns and
// extends load data.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, misaligned
// half/word accesses complete at once with err=1 and never reach the bus.
// When undefined, such accesses are aligned down and complete normally.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALU_out,
  input  logic [31:0] store_data,
  output logic [31:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off;
  logic [2:0]       f3;
  logic             is_load;
  logic             start;
  logic             misaligned;

  // Access size from funct3: 0 = byte, 1 = half, 2 = word (unlisted codes act as word)
  function automatic logic [1:0] size_of(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: size_of = 2'd0;
      3'b001, 3'b101: size_of = 2'd1;
      default:        size_of = 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] be_calc(input logic [2:0] f, input logic [1:0] a);
    case (size_of(f))
      2'd0:    be_calc = 4'b0001 << a;
      2'd1:    be_calc = 4'b0011 << {a[1], 1'b0};
      default: be_calc = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_calc(input logic [2:0] f, input logic [31:0] sd);
    case (size_of(f))
      2'd0:    wdata_calc = {4{sd[7:0]}};
      2'd1:    wdata_calc = {2{sd[15:0]}};
      default: wdata_calc = sd;
    endcase
  endfunction

  // Pick the addressed lane and extend: funct3[2] set means zero-extend
  function automatic logic [31:0] load_extract(input logic [2:0] f, input logic [1:0] a,
                                               input logic [31:0] rd);
    logic [31:0] bsh;
    logic [31:0] hsh;
    bsh = rd >> {a, 3'b000};
    hsh = rd >> {a[1], 4'b0000};
    case (size_of(f))
      2'd0:    load_extract = {{24{bsh[7] & ~f[2]}}, bsh[7:0]};
      2'd1:    load_extract = {{16{hsh[15] & ~f[2]}}, hsh[15:0]};
      default: load_extract = rd;
    endcase
  endfunction

  assign start = req_valid & (mem_read ^ mem_write);

  // Misalignment: half on odd address, or word not on a 4-byte boundary
  always_comb begin
    misaligned = 1'b0;
    case (size_of(funct3))
      2'd1:    misaligned = ALU_out[0];
      2'd2:    misaligned = |ALU_out[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign stall = ((state == IDLE) && start) || (state == REQ);

  // Access FSM with registered bus signals, status pulses and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      off       <= '0;
      f3        <= '0;
      is_load   <= 1'b0;
      data_out  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (TRAP_EN && misaligned) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= mem_write;
              mem_addr  <= {ALU_out[31:2], 2'b00};
              mem_be    <= be_calc(funct3, ALU_out[1:0]);
              mem_wdata <= wdata_calc(funct3, store_data);
              off       <= ALU_out[1:0];
              f3        <= funct3;
              is_load   <= mem_read;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state   <= DONE;
            done    <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (is_load) data_out <= load_extract(f3, off, mem_rdata);
          end else if (cnt == CNT_LAST) begin
            state   <= DONE;
            done    <= 1'b1;
            err     <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (is_load) data_out <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
